// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: SPI master register offsets and sequencer state encoding
package spi_flash_pkg;
    localparam logic [7:0] REG_DATA = 8'h00;
    localparam logic [7:0] REG_STAT = 8'h04;
    localparam logic [7:0] REG_CS   = 8'h08;
    localparam logic [7:0] REG_DIV  = 8'h10;
    typedef logic [3:0] state_t;
    localparam state_t ST_INIT  = 4'd0;
    localparam state_t ST_IDLE  = 4'd1;
    localparam state_t ST_DIV   = 4'd2;
    localparam state_t ST_CSON  = 4'd3;
    localparam state_t ST_TX    = 4'd4;
    localparam state_t ST_POLL  = 4'd5;
    localparam state_t ST_RD    = 4'd6;
    localparam state_t ST_OUT   = 4'd7;
    localparam state_t ST_CSOFF = 4'd8;
endpackage

// File: rtl/spi_wbm_port.sv
// spi_wbm_port: single-access Wishbone master; cyc drops on the ack edge so the next access always sees an idle cycle
module spi_wbm_port (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] dat,
    output logic        done,
    output logic [31:0] rdata,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    input  logic        wbm_ack_i
);
    assign wbm_sel_o = 4'hF;
    assign wbm_stb_o = wbm_cyc_o;
    always_ff @(posedge clk) begin
        if (reset) begin
            wbm_cyc_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= 32'h0;
            wbm_dat_o <= 32'h0;
            done      <= 1'b0;
            rdata     <= 32'h0;
        end else begin
            done <= 1'b0;
            if (!wbm_cyc_o && start) begin
                wbm_cyc_o <= 1'b1;
                wbm_we_o  <= we;
                wbm_adr_o <= adr;
                wbm_dat_o <= dat;
            end else if (wbm_cyc_o && wbm_ack_i) begin
                wbm_cyc_o <= 1'b0;
                wbm_we_o  <= 1'b0;
                done      <= 1'b1;
                rdata     <= wbm_dat_i;
            end
        end
    end
endmodule

// File: rtl/spi_flash_seq.sv
// spi_flash_seq: drives the byte-wide SPI master through select/cmd/addr/dummy-read/deselect transactions
module spi_flash_seq
    import spi_flash_pkg::*;
#(
    parameter logic [31:0] SPI_BASE   = 32'h0000_0000,
    parameter logic [7:0]  CS_SEL     = 8'hFE,
    parameter logic [7:0]  CS_IDLE    = 8'hFF,
    parameter logic [7:0]  DIVISOR    = 8'h04,
    parameter int          ADDR_BYTES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_cmd,
    input  logic [31:0] req_addr,
    input  logic [15:0] req_len,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    input  logic        wbm_ack_i
);
    state_t      state;
    logic        acc, start, we, pdone, hdr;
    logic [7:0]  off, wdat, cmd_q;
    logic [31:0] addr_q, addr_sh, prdata;
    logic [15:0] rem;
    logic [2:0]  hidx;
    logic        unused;
    assign req_ready = state == ST_IDLE;
    assign busy      = state != ST_IDLE && state != ST_INIT;
    assign addr_sh   = addr_q >> {3'(ADDR_BYTES) - hidx, 3'b000};
    assign unused    = ^{prdata[31:8], addr_sh[31:8]};
    always_comb begin
        start = !acc && state != ST_IDLE && state != ST_OUT;
        we    = state != ST_POLL && state != ST_RD;
        off   = state == ST_DIV ? REG_DIV :
                state == ST_POLL ? REG_STAT :
                (state == ST_TX || state == ST_RD) ? REG_DATA : REG_CS;
        wdat  = state == ST_DIV ? DIVISOR :
                state == ST_CSON ? CS_SEL :
                state == ST_TX ? (!hdr ? 8'h00 : hidx == 3'd0 ? cmd_q : addr_sh[7:0]) :
                (state == ST_INIT || state == ST_CSOFF) ? CS_IDLE : 8'h00;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_INIT;
            acc      <= 1'b0;
            done     <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= 8'h00;
            cmd_q    <= 8'h00;
            addr_q   <= 32'h0;
            rem      <= 16'h0;
            hidx     <= 3'd0;
            hdr      <= 1'b0;
        end else begin
            done <= 1'b0;
            acc  <= start ? 1'b1 : pdone ? 1'b0 : acc;
            case (state)
                ST_INIT:  if (pdone) state <= ST_IDLE;
                ST_IDLE:  if (req_valid) begin
                    cmd_q  <= req_cmd;
                    addr_q <= req_addr;
                    rem    <= req_len;
                    hidx   <= 3'd0;
                    hdr    <= 1'b1;
                    state  <= ST_DIV;
                end
                ST_DIV:   if (pdone) state <= ST_CSON;
                ST_CSON:  if (pdone) state <= ST_TX;
                ST_TX:    if (pdone) state <= ST_POLL;
                ST_POLL:  if (pdone && !prdata[0]) begin
                    if (!hdr) state <= ST_RD;
                    else if (hidx != 3'(ADDR_BYTES)) begin
                        hidx  <= hidx + 3'd1;
                        state <= ST_TX;
                    end else begin
                        hdr   <= 1'b0;
                        state <= rem == 16'd0 ? ST_CSOFF : ST_TX;
                    end
                end
                ST_RD:    if (pdone) begin
                    rx_data  <= prdata[7:0];
                    rx_valid <= 1'b1;
                    state    <= ST_OUT;
                end
                ST_OUT:   if (rx_ready) begin
                    rx_valid <= 1'b0;
                    rem      <= rem - 16'd1;
                    state    <= rem == 16'd1 ? ST_CSOFF : ST_TX;
                end
                ST_CSOFF: if (pdone) begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default:  state <= ST_INIT;
            endcase
        end
    end
    spi_wbm_port u_port (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .we        (we),
        .adr       (SPI_BASE + {24'h0, off}),
        .dat       ({24'h0, wdat}),
        .done      (pdone),
        .rdata     (prdata),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_sel_o (wbm_sel_o),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_ack_i (wbm_ack_i)
    );
endmodule

// File: tb/tb_spi_flash_seq.sv
// tb_spi_flash_seq: scoreboard bench with an SPI master register model on the Wishbone side
module tb_spi_flash_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_cmd = 8'h00;
    logic [31:0] req_addr = 32'h0;
    logic [15:0] req_len = 16'h0;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b1;
    logic        busy, done;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic [3:0]  wbm_sel_o;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    int          checks = 0, errors = 0;
    logic [63:0] exp_wr[$];
    logic [7:0]  exp_rx[$];
    logic [7:0]  miso_q[$];
    int          ack_dly = 0, poll_n = 1, stat_left = 0, cnt = 0;
    int          n_data_wr = 0, done_cnt = 0;
    logic [63:0] last_wr = 64'h0;
    logic        gap_need = 1'b0;

    spi_flash_seq dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_addr(req_addr), .req_len(req_len),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .busy(busy), .done(done),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
        .wbm_sel_o(wbm_sel_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
        .wbm_we_o(wbm_we_o), .wbm_ack_i(wbm_ack_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // register model: registered ack after ack_dly wait cycles; status stays running for poll_n reads after each data write
    always @(posedge clk) begin
        if (reset) begin
            wbm_ack_i <= 1'b0;
            wbm_dat_i <= 32'h0;
            cnt       <= 0;
            stat_left <= 0;
        end else if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i) begin
            if (cnt >= ack_dly) begin
                wbm_ack_i <= 1'b1;
                cnt       <= 0;
                if (wbm_we_o) begin
                    if (wbm_adr_o == 32'h0) stat_left <= poll_n;
                end else if (wbm_adr_o == 32'h4) begin
                    wbm_dat_i <= {31'h0, stat_left != 0};
                    if (stat_left != 0) stat_left <= stat_left - 1;
                end else if (wbm_adr_o == 32'h0) begin
                    if (miso_q.size() != 0) wbm_dat_i <= {24'h0, miso_q.pop_front()};
                    else wbm_dat_i <= 32'hEE;
                end else wbm_dat_i <= 32'h0;
            end else cnt <= cnt + 1;
        end else begin
            wbm_ack_i <= 1'b0;
            cnt       <= 0;
        end
    end

    always @(negedge clk) begin
        if (reset) gap_need <= 1'b0;
        else begin
            if (gap_need) check("cyc_gap", 64'(wbm_cyc_o), 64'd0);
            gap_need <= wbm_cyc_o && wbm_ack_i;
            if (wbm_cyc_o && wbm_ack_i) begin
                check("stb", 64'(wbm_stb_o), 64'd1);
                check("sel", 64'(wbm_sel_o), 64'hF);
            end
            if (wbm_cyc_o && wbm_ack_i && wbm_we_o) begin
                if (wbm_adr_o == 32'h0) n_data_wr <= n_data_wr + 1;
                last_wr <= {wbm_adr_o, wbm_dat_o};
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_unexpected: got %0h expected none", {wbm_adr_o, wbm_dat_o});
                end else check("wr", {wbm_adr_o, wbm_dat_o}, exp_wr.pop_front());
            end
            if (rx_valid && rx_ready) begin
                if (exp_rx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected: got %0h expected none", rx_data);
                end else check("rx_data", 64'(rx_data), 64'(exp_rx.pop_front()));
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                check("done_after_csoff", last_wr, {32'h8, 32'hFF});
            end
        end
    end

    task automatic ew(input logic [7:0] a, input logic [7:0] d);
        exp_wr.push_back({24'h0, a, 24'h0, d});
    endtask

    task automatic hdr_exp(input logic [7:0] c, input logic [23:0] a);
        ew(8'h10, 8'h04);
        ew(8'h08, 8'hFE);
        ew(8'h00, c);
        ew(8'h00, a[23:16]);
        ew(8'h00, a[15:8]);
        ew(8'h00, a[7:0]);
    endtask

    task automatic reset_checks();
        check("rst_ctrl", 64'({wbm_cyc_o, wbm_stb_o, wbm_we_o, req_ready, rx_valid, busy, done}), 64'd0);
        check("rst_adr", 64'(wbm_adr_o), 64'd0);
        check("rst_dat", 64'(wbm_dat_o), 64'd0);
        check("rst_sel", 64'(wbm_sel_o), 64'hF);
        check("rst_rx_data", 64'(rx_data), 64'd0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_wait", 64'(req_ready), 64'd1);
    endtask

    task automatic issue(input logic [7:0] c, input logic [31:0] a, input logic [15:0] l);
        wait_ready();
        req_cmd = c;
        req_addr = a;
        req_len = l;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_cmd = 8'h5C;
        req_addr = 32'hDEAD_BEEF;
        req_len = 16'hFFFF;
        check("busy_after_accept", 64'(busy), 64'd1);
    endtask

    task automatic finish_txn(input int exp_done);
        int n = 0;
        while (done_cnt < exp_done && n < 20000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("done_count", 64'(done_cnt), 64'(exp_done));
        check("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
        check("rx_queue_empty", 64'(exp_rx.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int nd, n;
        repeat (3) @(negedge clk);
        reset_checks();
        ew(8'h08, 8'hFF);
        reset = 1'b0;
        @(negedge clk);
        check("ready_before_init", 64'(req_ready), 64'd0);
        wait_ready();
        check("init_write_first", 64'(exp_wr.size()), 64'd0);

        hdr_exp(8'h03, 24'h012345);
        ew(8'h00, 8'h00);
        ew(8'h00, 8'h00);
        ew(8'h08, 8'hFF);
        miso_q = '{8'hA5, 8'h5A};
        exp_rx = '{8'hA5, 8'h5A};
        issue(8'h03, 32'h0001_2345, 16'd2);
        finish_txn(1);

        nd = n_data_wr;
        hdr_exp(8'h06, 24'h000000);
        ew(8'h08, 8'hFF);
        issue(8'h06, 32'h0, 16'd0);
        finish_txn(2);
        check("len0_tx_bytes", 64'(n_data_wr - nd), 64'd4);

        hdr_exp(8'h03, 24'h000010);
        ew(8'h00, 8'h00);
        ew(8'h00, 8'h00);
        ew(8'h08, 8'hFF);
        miso_q = '{8'h77, 8'h88};
        exp_rx = '{8'h77, 8'h88};
        rx_ready = 1'b0;
        issue(8'h03, 32'h10, 16'd2);
        n = 0;
        while (!rx_valid && n < 5000) begin
            @(negedge clk);
            n++;
        end
        nd = n_data_wr;
        for (int i = 0; i < 50; i++) begin
            check("rx_stall_hold", 64'({rx_valid, rx_data}), 64'h177);
            @(negedge clk);
        end
        check("no_tx_during_stall", 64'(n_data_wr - nd), 64'd0);
        @(posedge clk) #1 rx_ready = 1'b1;
        finish_txn(3);

        ack_dly = 3;
        poll_n = 40;
        hdr_exp(8'h0B, 24'hABCDEF);
        ew(8'h00, 8'h00);
        ew(8'h08, 8'hFF);
        miso_q = '{8'hC3};
        exp_rx = '{8'hC3};
        issue(8'h0B, 32'h00AB_CDEF, 16'd1);
        finish_txn(4);
        ack_dly = 0;
        poll_n = 1;

        hdr_exp(8'h03, 24'h0A0B0C);
        ew(8'h00, 8'h00);
        ew(8'h00, 8'h00);
        miso_q = '{8'h11, 8'h22, 8'h33};
        exp_rx = '{8'h11};
        nd = n_data_wr;
        issue(8'h03, 32'h000A_0B0C, 16'd3);
        n = 0;
        while (n_data_wr - nd < 6 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("reached_dummy2", 64'(n_data_wr - nd), 64'd6);
        check("pre_reset_wr_empty", 64'(exp_wr.size()), 64'd0);
        check("pre_reset_rx_empty", 64'(exp_rx.size()), 64'd0);
        reset = 1'b1;
        miso_q.delete();
        @(posedge clk) #1;
        reset_checks();
        ew(8'h08, 8'hFF);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("ready_before_reinit", 64'(req_ready), 64'd0);
        wait_ready();
        check("reinit_write_first", 64'(exp_wr.size()), 64'd0);
        check("no_done_on_abort", 64'(done_cnt), 64'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
